// File: rtl/calc_sequencer.sv
// Keypad-driven calculator sequencer: collects two decimal operands and an operator,
// runs one external ALU operation with a completion timeout, and shows the result.
module calc_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_stop,
  input  logic [3:0] key_digit,
  input  logic [3:0] key_sym,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  output logic       alu_start,
  input  logic       alu_done,
  input  logic [7:0] alu_result,
  output logic [7:0] disp,
  output logic       result_valid,
  output logic       busy,
  output logic       err
);

  localparam int unsigned CW  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int unsigned ACW = 12;

  typedef enum logic [2:0] {S_A, S_B, EXEC, WAIT, SHOW} state_t;

  state_t         state, state_n;
  logic [7:0]     a, a_n, b, b_n, r, r_n;
  logic [2:0]     op, op_n;
  logic [1:0]     bcnt, bcnt_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           armed, armed_n;
  logic           err_n, rv_n, start_n;
  logic [7:0]     alu_a_n, alu_b_n;
  logic [2:0]     alu_op_n;

  logic           sym_digit, sym_op, sym_eq;
  logic [2:0]     op_code;
  logic           accept, ev_digit, ev_op, ev_eq;
  logic [ACW-1:0] acc_a, acc_b;
  logic           a_fits, b_fits;

  // Symbol decode; unknown codes belong to no class and never consume the press
  always_comb begin
    sym_digit = 1'b0;
    sym_op    = 1'b0;
    sym_eq    = 1'b0;
    op_code   = 3'd0;
    case (key_sym)
      4'b1111: sym_digit = 1'b1;
      4'b0001: begin sym_op = 1'b1; op_code = 3'b000; end
      4'b0010: begin sym_op = 1'b1; op_code = 3'b001; end
      4'b0011: begin sym_op = 1'b1; op_code = 3'b010; end
      4'b0101: begin sym_op = 1'b1; op_code = 3'b011; end
      4'b0110: begin sym_op = 1'b1; op_code = 3'b100; end
      4'b0100: sym_eq = 1'b1;
      default: ;
    endcase
  end

  assign accept   = armed & key_stop & (sym_digit | sym_op | sym_eq);
  assign ev_digit = accept & sym_digit;
  assign ev_op    = accept & sym_op;
  assign ev_eq    = accept & sym_eq;

  assign acc_a  = ACW'(a) * ACW'(10) + ACW'(key_digit);
  assign acc_b  = ACW'(b) * ACW'(10) + ACW'(key_digit);
  assign a_fits = (acc_a <= ACW'(255));
  assign b_fits = (acc_b <= ACW'(255));

  // Next-state and datapath update
  always_comb begin
    state_n  = state;
    a_n      = a;
    b_n      = b;
    r_n      = r;
    op_n     = op;
    bcnt_n   = bcnt;
    cnt_n    = cnt;
    err_n    = err;
    rv_n     = 1'b0;
    start_n  = 1'b0;
    alu_a_n  = alu_a;
    alu_b_n  = alu_b;
    alu_op_n = alu_op;
    armed_n  = accept ? 1'b0 : (!key_stop ? 1'b1 : armed);

    case (state)
      S_A: begin
        if (ev_digit) begin
          if (a_fits) a_n = acc_a[7:0];
        end else if (ev_op) begin
          op_n    = op_code;
          b_n     = 8'd0;
          bcnt_n  = 2'd0;
          state_n = S_B;
        end
      end
      S_B: begin
        if (ev_digit) begin
          if (b_fits) begin
            b_n    = acc_b[7:0];
            bcnt_n = (bcnt == 2'd3) ? bcnt : bcnt + 2'd1;
          end
        end else if (ev_op && bcnt == 2'd0) begin
          op_n = op_code;
        end else if (ev_eq && bcnt != 2'd0) begin
          alu_a_n  = a;
          alu_b_n  = b;
          alu_op_n = op;
          start_n  = 1'b1;
          state_n  = EXEC;
        end
      end
      EXEC: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (alu_done) begin
          r_n     = alu_result;
          rv_n    = 1'b1;
          state_n = SHOW;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          r_n     = 8'd0;
          state_n = SHOW;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SHOW: begin
        if (ev_digit) begin
          a_n     = 8'(key_digit);
          err_n   = 1'b0;
          state_n = S_A;
        end else if (ev_op) begin
          a_n     = r;
          op_n    = op_code;
          b_n     = 8'd0;
          bcnt_n  = 2'd0;
          err_n   = 1'b0;
          state_n = S_B;
        end
      end
      default: state_n = S_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_A;
      a            <= 8'd0;
      b            <= 8'd0;
      r            <= 8'd0;
      op           <= 3'd0;
      bcnt         <= 2'd0;
      cnt          <= '0;
      armed        <= 1'b1;
      err          <= 1'b0;
      result_valid <= 1'b0;
      alu_start    <= 1'b0;
      alu_a        <= 8'd0;
      alu_b        <= 8'd0;
      alu_op       <= 3'd0;
    end else begin
      state        <= state_n;
      a            <= a_n;
      b            <= b_n;
      r            <= r_n;
      op           <= op_n;
      bcnt         <= bcnt_n;
      cnt          <= cnt_n;
      armed        <= armed_n;
      err          <= err_n;
      result_valid <= rv_n;
      alu_start    <= start_n;
      alu_a        <= alu_a_n;
      alu_b        <= alu_b_n;
      alu_op       <= alu_op_n;
    end
  end

  assign busy = (state == EXEC) || (state == WAIT);

  // Display source follows the operand being edited, or the result
  always_comb begin
    case (state)
      S_B:     disp = (bcnt == 2'd0) ? a : b;
      SHOW:    disp = r;
      default: disp = a;
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: directed key sequences, a behavioural ALU,
// and a monitor checking ALU launches and results against queued expectations.
module tb_calc_sequencer;

  localparam logic [3:0] SYM_DIG = 4'b1111;
  localparam logic [3:0] SYM_ADD = 4'b0001;
  localparam logic [3:0] SYM_SUB = 4'b0010;
  localparam logic [3:0] SYM_EQ  = 4'b0100;
  localparam logic [3:0] SYM_OR  = 4'b0110;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_stop = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic [3:0] key_sym = 4'd0;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic       alu_start;
  logic       alu_done = 1'b0;
  logic [7:0] alu_result = 8'd0;
  logic [7:0] disp;
  logic       result_valid, busy, err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;

  logic [18:0] exp_start_q[$];
  int          exp_res_q[$];
  logic [18:0] last_ops = '0;
  logic [18:0] cur_ops;
  logic        prev_start = 1'b0;
  int          exp_val;

  logic       alu_en  = 1'b1;
  int         alu_lat = 1;
  logic [7:0] alu_res = 8'd0;

  calc_sequencer #(.TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .key_stop(key_stop), .key_digit(key_digit), .key_sym(key_sym),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .disp(disp),
    .result_valid(result_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural ALU: answers alu_lat cycles after each start pulse
  always begin
    @(negedge clk);
    if (alu_start && alu_en) begin
      repeat (alu_lat) @(negedge clk);
      alu_done   = 1'b1;
      alu_result = alu_res;
      @(negedge clk);
      alu_done = 1'b0;
    end
  end

  // Monitor: ALU launches, operand stability while busy, latched results
  always @(negedge clk) begin
    cur_ops = {alu_a, alu_b, alu_op};
    if (alu_start) begin
      n_starts++;
      check("alu_start_single_cycle", int'(prev_start), 0);
      check("alu_start_expected", int'(exp_start_q.size() != 0), 1);
      if (exp_start_q.size() != 0) check("alu_operands", int'(cur_ops), int'(exp_start_q.pop_front()));
      last_ops = cur_ops;
    end else if (busy) begin
      check("alu_operands_stable", int'(cur_ops), int'(last_ops));
    end
    prev_start = alu_start;
    if (result_valid) begin
      check("result_valid_expected", int'(exp_res_q.size() != 0), 1);
      if (exp_res_q.size() != 0) begin
        exp_val = exp_res_q.pop_front();
        check("result_disp", int'(disp), exp_val);
      end
    end
  end

  task automatic press(input logic [3:0] sym, input logic [3:0] dig, input int hold);
    @(negedge clk);
    key_stop  = 1'b1;
    key_sym   = sym;
    key_digit = dig;
    repeat (hold) @(negedge clk);
    key_stop = 1'b0;
    key_sym  = 4'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("wait_idle_bound", int'(busy), 0);
    @(negedge clk);
  endtask

  initial begin
    int busy_cycles;
    int seen;

    // Reset state
    do_reset();
    check("rst_disp", int'(disp), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    check("rst_alu_start", int'(alu_start), 0);
    check("rst_result_valid", int'(result_valid), 0);
    check("rst_alu_a", int'(alu_a), 0);

    // 12 + 3 with ALU answering 15 after 4 cycles
    press(SYM_DIG, 4'd1, 1);
    press(SYM_DIG, 4'd2, 1);
    check("a_12", int'(disp), 12);
    press(SYM_ADD, 4'd0, 1);
    check("sb_shows_a", int'(disp), 12);
    press(SYM_DIG, 4'd3, 1);
    check("b_3", int'(disp), 3);
    exp_start_q.push_back({8'd12, 8'd3, 3'b000});
    exp_res_q.push_back(15);
    alu_lat = 4; alu_res = 8'd15;
    press(SYM_EQ, 4'd0, 1);
    wait_idle();
    check("show_15", int'(disp), 15);
    check("starts_after_add", n_starts, 1);

    // Chaining: or 6 on previous result
    press(SYM_OR, 4'd0, 1);
    check("chain_a_is_r", int'(disp), 15);
    press(SYM_DIG, 4'd6, 1);
    exp_start_q.push_back({8'd15, 8'd6, 3'b100});
    exp_res_q.push_back(15);
    alu_lat = 2; alu_res = 8'd15;
    press(SYM_EQ, 4'd0, 1);
    wait_idle();
    check("chain_show", int'(disp), 15);

    // Held key counts once
    press(SYM_DIG, 4'd7, 20);
    check("held_7", int'(disp), 7);
    press(SYM_DIG, 4'd7, 1);
    check("second_7", int'(disp), 77);
    check("s_a_not_busy", int'(busy), 0);

    // Overflow guard, op replacement, equals ignored without B digits
    do_reset();
    press(SYM_DIG, 4'd2, 1);
    press(SYM_DIG, 4'd5, 1);
    press(SYM_DIG, 4'd5, 1);
    check("a_255", int'(disp), 255);
    press(SYM_DIG, 4'd9, 1);
    check("a_overflow_ignored", int'(disp), 255);
    press(SYM_ADD, 4'd0, 1);
    press(SYM_SUB, 4'd0, 1);
    press(SYM_EQ, 4'd0, 1);
    check("eq_ignored_no_b", int'(busy), 0);
    check("sb_disp_a", int'(disp), 255);
    press(SYM_DIG, 4'd1, 1);
    check("b_1", int'(disp), 1);
    exp_start_q.push_back({8'd255, 8'd1, 3'b001});
    exp_res_q.push_back(254);
    alu_lat = 1; alu_res = 8'd254;
    press(SYM_EQ, 4'd0, 1);
    wait_idle();
    check("show_254", int'(disp), 254);

    // Timeout with a discarded key press during WAIT
    press(SYM_DIG, 4'd3, 1);
    press(SYM_ADD, 4'd0, 1);
    press(SYM_DIG, 4'd4, 1);
    exp_start_q.push_back({8'd3, 8'd4, 3'b000});
    alu_en = 1'b0;
    @(negedge clk);
    key_stop = 1'b1; key_sym = SYM_EQ;
    busy_cycles = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (i == 0 || i == 53) begin key_stop = 1'b0; key_sym = 4'd0; end
      if (i == 50) begin key_stop = 1'b1; key_sym = SYM_DIG; key_digit = 4'd9; end
      if (busy) busy_cycles++;
      else if (i > 0) break;
    end
    check("timeout_busy_cycles", busy_cycles, 256);
    check("timeout_err", int'(err), 1);
    check("timeout_disp", int'(disp), 0);
    repeat (2) @(negedge clk);
    alu_en = 1'b1;
    press(SYM_DIG, 4'd4, 1);
    check("err_cleared", int'(err), 0);
    check("after_err_disp", int'(disp), 4);
    check("after_err_idle", int'(busy), 0);

    // alu_done on the final WAIT cycle wins over the timeout
    press(SYM_ADD, 4'd0, 1);
    press(SYM_DIG, 4'd5, 1);
    exp_start_q.push_back({8'd4, 8'd5, 3'b000});
    exp_res_q.push_back(9);
    alu_lat = 255; alu_res = 8'd9;
    press(SYM_EQ, 4'd0, 1);
    wait_idle();
    check("late_done_no_err", int'(err), 0);
    check("late_done_disp", int'(disp), 9);

    // Reset during WAIT; the ALU answer arriving afterwards is ignored
    press(SYM_DIG, 4'd1, 1);
    press(SYM_ADD, 4'd0, 1);
    press(SYM_DIG, 4'd2, 1);
    exp_start_q.push_back({8'd1, 8'd2, 3'b000});
    alu_lat = 4; alu_res = 8'd3;
    @(negedge clk);
    key_stop = 1'b1; key_sym = SYM_EQ;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (alu_start) begin seen = 1; break; end
    end
    check("rst_wait_started", seen, 1);
    key_stop = 1'b0; key_sym = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_wait_disp", int'(disp), 0);
    check("rst_wait_busy", int'(busy), 0);
    check("rst_wait_err", int'(err), 0);
    check("rst_wait_alu_a", int'(alu_a), 0);

    check("start_queue_drained", exp_start_q.size(), 0);
    check("result_queue_drained", exp_res_q.size(), 0);
    check("total_starts", n_starts, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
